// File: rtl/decode_issue_scoreboard_pkg.sv
// Shared opcode constants and branch-wait FSM encoding for the decode issue scoreboard.
package decode_issue_scoreboard_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_OP32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_JALR     = 5'b11001;

  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_WAIT = 1'b1
  } br_state_e;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register in-flight write counters. Register 0 is never tracked; increments stop at the
// maximum count and a writeback to an idle register raises a sticky error instead of wrapping.
module sb_counter_bank #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc_en,
  input  logic [IDX_W-1:0] i_inc_idx,
  input  logic             i_dec_en,
  input  logic [IDX_W-1:0] i_dec_idx,
  output logic [NREG-1:0]  o_pending,
  output logic [NREG-1:0]  o_full,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt   [NREG];
  logic [CNT_W-1:0] w_cnt_d [NREG];
  logic             r_err;
  logic             w_underflow;

  always_comb begin
    w_cnt_d     = r_cnt;
    w_underflow = i_dec_en && (i_dec_idx != '0) && (r_cnt[i_dec_idx] == '0);
    for (int r = 1; r < NREG; r++) begin
      // Coincident inc and dec on one register cancel out.
      if (i_inc_en && (i_inc_idx == IDX_W'(r)) && (r_cnt[r] != CNT_MAX) &&
          !(i_dec_en && (i_dec_idx == IDX_W'(r)) && (r_cnt[r] != '0))) begin
        w_cnt_d[r] = r_cnt[r] + CNT_W'(1);
      end else if (i_dec_en && (i_dec_idx == IDX_W'(r)) && (r_cnt[r] != '0) &&
                   !(i_inc_en && (i_inc_idx == IDX_W'(r)))) begin
        w_cnt_d[r] = r_cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      if (w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    o_pending = '0;
    o_full    = '0;
    for (int r = 0; r < NREG; r++) begin
      o_pending[r] = (r_cnt[r] != '0);
      o_full[r]    = (r_cnt[r] == CNT_MAX);
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/decode_issue_scoreboard.sv
// Decode-stage issue control: scoreboard hazard check plus branch-wait FSM holding decode/fetch.
// Define SB_PERF_CNT_EN to add the hazard/branch stall performance counters.
module decode_issue_scoreboard
  import decode_issue_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned NREG  = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DE_V,
  input  logic [31:0] DE_IR,
  input  logic        WB_V,
  input  logic [4:0]  WB_DR,
  input  logic        WB_REG_WEN,
  input  logic        BR_RESOLVE,
  output logic        stall,
  output logic        ISSUE,
  output logic        V_DE_FE_BR_STALL,
  output logic [31:0] SB_PENDING,
  output logic        BR_WAIT_Q,
  output logic        SB_ERR
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0] PERF_HAZ_STALLS,
  output logic [31:0] PERF_BR_STALLS
`endif
);

  logic [4:0]      w_op, w_rs1, w_rs2, w_rd;
  logic            w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_ctrl;
  logic            w_src_haz, w_waw_full;
  logic [NREG-1:0] w_pending, w_full;
  logic            w_unused_ir;
  br_state_e       r_state, w_state_d;

  assign w_op  = DE_IR[6:2];
  assign w_rs1 = DE_IR[19:15];
  assign w_rs2 = DE_IR[24:20];
  assign w_rd  = DE_IR[11:7];
  assign w_unused_ir = ^{DE_IR[31:25], DE_IR[14:12], DE_IR[1:0]};

  always_comb begin
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    w_writes_rd = 1'b0;
    w_is_ctrl   = 1'b0;
    case (w_op)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: begin
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_STORE: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_OP, OPC_OP32: begin
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: w_writes_rd = 1'b1;
      OPC_BRANCH: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_is_ctrl  = 1'b1;
      end
      OPC_JAL: begin
        w_writes_rd = 1'b1;
        w_is_ctrl   = 1'b1;
      end
      OPC_JALR: begin
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
        w_is_ctrl   = 1'b1;
      end
      default: ;
    endcase
    if (w_rd == 5'd0) begin
      w_writes_rd = 1'b0;
    end
  end

  // Hazards use registered counts only; a same-cycle writeback does not bypass.
  assign w_src_haz  = (w_uses_rs1 && w_pending[w_rs1]) || (w_uses_rs2 && w_pending[w_rs2]);
  assign w_waw_full = w_writes_rd && w_full[w_rd];

  assign BR_WAIT_Q        = (r_state == BR_WAIT);
  assign stall            = DE_V && (BR_WAIT_Q || w_src_haz || w_waw_full);
  assign ISSUE            = DE_V && !stall;
  assign V_DE_FE_BR_STALL = BR_WAIT_Q || (DE_V && w_is_ctrl);

  sb_counter_bank #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_bank (
    .i_clk     (CLK),
    .i_reset   (RESET),
    .i_inc_en  (ISSUE && w_writes_rd),
    .i_inc_idx (w_rd),
    .i_dec_en  (WB_V && WB_REG_WEN),
    .i_dec_idx (WB_DR),
    .o_pending (w_pending),
    .o_full    (w_full),
    .o_err     (SB_ERR)
  );

  assign SB_PENDING = w_pending;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      BR_IDLE: if (ISSUE && w_is_ctrl) w_state_d = BR_WAIT;
      BR_WAIT: if (BR_RESOLVE) w_state_d = BR_IDLE;
      default: w_state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= BR_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

`ifdef SB_PERF_CNT_EN
  logic [31:0] r_perf_haz, r_perf_br;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_perf_haz <= '0;
      r_perf_br  <= '0;
    end else begin
      if (DE_V && !BR_WAIT_Q && (w_src_haz || w_waw_full)) begin
        r_perf_haz <= r_perf_haz + 32'd1;
      end
      if (BR_WAIT_Q) begin
        r_perf_br <= r_perf_br + 32'd1;
      end
    end
  end

  assign PERF_HAZ_STALLS = r_perf_haz;
  assign PERF_BR_STALLS  = r_perf_br;
`endif

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Directed self-checking bench for decode_issue_scoreboard (default build, no perf counters).
module tb_decode_issue_scoreboard;

  logic        clk, rst, de_v, wb_v, wb_wen, br_res;
  logic [31:0] de_ir;
  logic [4:0]  wb_dr;
  logic        stall_o, issue_o, brstall_o, brwait_o, err_o;
  logic [31:0] pend_o;
  int          n_checks = 0;
  int          n_fail   = 0;

  decode_issue_scoreboard dut (
    .CLK              (clk),
    .RESET            (rst),
    .DE_V             (de_v),
    .DE_IR            (de_ir),
    .WB_V             (wb_v),
    .WB_DR            (wb_dr),
    .WB_REG_WEN       (wb_wen),
    .BR_RESOLVE       (br_res),
    .stall            (stall_o),
    .ISSUE            (issue_o),
    .V_DE_FE_BR_STALL (brstall_o),
    .SB_PENDING       (pend_o),
    .BR_WAIT_Q        (brwait_o),
    .SB_ERR           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock, then let combinational outputs settle on the new state.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction

  task automatic wb(input logic en, input logic [4:0] dr);
    wb_v   = en;
    wb_wen = en;
    wb_dr  = dr;
  endtask

  initial begin
    rst = 1'b1; de_v = 1'b0; de_ir = '0; wb_v = 1'b0; wb_wen = 1'b0; wb_dr = '0; br_res = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_pending", pend_o, 32'h0);
    check("rst_brwait", {31'd0, brwait_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);

    // Simple issue and retire.
    de_v = 1'b1; de_ir = addi(5'd5, 5'd0); #1;
    check("addi5_issue", {31'd0, issue_o}, 32'd1);
    check("addi5_stall", {31'd0, stall_o}, 32'd0);
    check("addi5_brstall", {31'd0, brstall_o}, 32'd0);
    tick();
    de_v = 1'b0; #1;
    check("pend5", pend_o, 32'h0000_0020);
    wb(1'b1, 5'd5);
    tick();
    wb(1'b0, 5'd0); #1;
    check("pend5_clear", pend_o, 32'h0);

    // RAW hazard, no bypass on a coincident writeback.
    de_v = 1'b1; de_ir = addi(5'd5, 5'd0);
    tick();
    de_ir = add(5'd6, 5'd5, 5'd5); #1;
    check("raw_stall", {31'd0, stall_o}, 32'd1);
    check("raw_noissue", {31'd0, issue_o}, 32'd0);
    tick();
    wb(1'b1, 5'd5); #1;
    check("raw_wb_same_cycle", {31'd0, stall_o}, 32'd1);
    tick();
    wb(1'b0, 5'd0); #1;
    check("raw_issue_after_wb", {31'd0, issue_o}, 32'd1);
    tick();
    de_v = 1'b0; #1;
    check("pend6", pend_o, 32'h0000_0040);
    wb(1'b1, 5'd6);
    tick();
    wb(1'b0, 5'd0);

    // WAW saturation on x7.
    de_v = 1'b1; de_ir = addi(5'd7, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("waw_issue%0d", i), {31'd0, issue_o}, 32'd1);
      tick();
    end
    check("waw_full_stall", {31'd0, stall_o}, 32'd1);
    check("waw_full_pend", pend_o, 32'h0000_0080);
    wb(1'b1, 5'd7); #1;
    check("waw_wb_same_cycle", {31'd0, issue_o}, 32'd0);
    tick();
    wb(1'b0, 5'd0); #1;
    check("waw_issue_after_wb", {31'd0, issue_o}, 32'd1);
    tick();
    de_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb(1'b1, 5'd7);
      tick();
    end
    wb(1'b0, 5'd0); #1;
    check("waw_drained", pend_o, 32'h0);
    check("waw_no_err", {31'd0, err_o}, 32'd0);

    // Branch wait.
    de_v = 1'b1; de_ir = beq(5'd1, 5'd2); #1;
    check("beq_issue", {31'd0, issue_o}, 32'd1);
    check("beq_brstall", {31'd0, brstall_o}, 32'd1);
    check("beq_brwait_pre", {31'd0, brwait_o}, 32'd0);
    tick();
    de_ir = addi(5'd8, 5'd0); #1;
    check("brwait_set", {31'd0, brwait_o}, 32'd1);
    check("brwait_stall", {31'd0, stall_o}, 32'd1);
    check("brwait_fetch", {31'd0, brstall_o}, 32'd1);
    tick();
    br_res = 1'b1; #1;
    check("resolve_cycle_stall", {31'd0, stall_o}, 32'd1);
    tick();
    br_res = 1'b0; #1;
    check("brwait_clear", {31'd0, brwait_o}, 32'd0);
    check("post_br_issue", {31'd0, issue_o}, 32'd1);
    check("post_br_fetch", {31'd0, brstall_o}, 32'd0);
    tick();
    de_v = 1'b0; #1;
    check("pend8", pend_o, 32'h0000_0100);
    wb(1'b1, 5'd8); br_res = 1'b1;
    tick();
    wb(1'b0, 5'd0); br_res = 1'b0; #1;
    check("idle_resolve_ignored", {31'd0, brwait_o}, 32'd0);
    de_v = 1'b1; de_ir = beq(5'd1, 5'd2); br_res = 1'b1;
    tick();
    de_v = 1'b0; br_res = 1'b0; #1;
    check("ctrl_and_resolve_idle", {31'd0, brwait_o}, 32'd1);
    br_res = 1'b1;
    tick();
    br_res = 1'b0;

    // Coincident inc/dec on x9, then underflow on x3 and a harmless x0 writeback.
    de_v = 1'b1; de_ir = addi(5'd9, 5'd0);
    tick();
    wb(1'b1, 5'd9); #1;
    check("inc_dec_issue", {31'd0, issue_o}, 32'd1);
    tick();
    de_v = 1'b0; wb(1'b1, 5'd9); #1;
    check("inc_dec_pend9", pend_o, 32'h0000_0200);
    tick();
    wb(1'b1, 5'd0); #1;
    check("inc_dec_single_wb_clears", pend_o, 32'h0);
    tick();
    wb(1'b1, 5'd3); #1;
    check("x0_wb_no_err", {31'd0, err_o}, 32'd0);
    tick();
    wb(1'b0, 5'd0); #1;
    check("underflow_err", {31'd0, err_o}, 32'd1);
    check("underflow_pend", pend_o, 32'h0);
    tick(); tick();
    check("err_sticky", {31'd0, err_o}, 32'd1);

    // Reset in BR_WAIT with pending writes.
    de_v = 1'b1; de_ir = addi(5'd5, 5'd0);
    tick(); tick();
    de_ir = beq(5'd1, 5'd2);
    tick();
    de_v = 1'b0; #1;
    check("pre_rst_brwait", {31'd0, brwait_o}, 32'd1);
    check("pre_rst_pend", pend_o, 32'h0000_0020);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("mid_rst_brwait", {31'd0, brwait_o}, 32'd0);
    check("mid_rst_pend", pend_o, 32'h0);
    check("mid_rst_err", {31'd0, err_o}, 32'd0);
    de_v = 1'b1; de_ir = add(5'd6, 5'd5, 5'd5); #1;
    check("post_rst_issue", {31'd0, issue_o}, 32'd1);
    check("post_rst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    de_v = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue_scoreboard.md
Name: decode_issue_scoreboard

Overview:
- Issue controller for the decode stage. Replaces the comparator-chain hazard check (EXE/MEM/WB destination vs rs1/rs2) with a per-register in-flight scoreboard.
- Sequences control-transfer instructions with a branch-wait FSM that holds decode and fetch until the branch resolves.
- Sits beside the decode stage. Drives decode stall and the fetch branch-stall. Consumes the writeback port to retire pending destinations.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter (max outstanding writes per register = 2^CNT_W-1)
- NREG, 32, architectural register count (x0 never tracked)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- DE_V  in  1  decode holds a valid instruction
- DE_IR  in  32  instruction in decode
- WB_V  in  1  writeback stage valid
- WB_DR  in  5  writeback destination register
- WB_REG_WEN  in  1  writeback writes register file
- BR_RESOLVE  in  1  one-cycle pulse: in-flight branch/jump resolved in EXE
- stall  out  1  decode must hold (combinational)
- ISSUE  out  1  instruction leaves decode this cycle (combinational)
- V_DE_FE_BR_STALL  out  1  fetch must hold for control transfer (combinational)
- SB_PENDING  out  32  bit r = counter[r]!=0 (registered state view)
- BR_WAIT_Q  out  1  FSM in BR_WAIT
- SB_ERR  out  1  sticky: writeback to a register with zero count

Behaviour:
- Decode fields:
  - op=DE_IR[6:2], rs1=[19:15], rs2=[24:20], rd=[11:7].
  - uses_rs1: op in {00000,00100,00110,01000,01100,01110,11000,11001}.
  - uses_rs2: op in {01000,01100,01110,11000}.
  - writes_rd: op in {00000,00100,00110,01100,01110,01101,00101,11011,11001} and rd!=0.
  - is_ctrl: op in {11000,11001,11011}.
- Hazards:
  - src_haz = (uses_rs1 && cnt[rs1]!=0) || (uses_rs2 && cnt[rs2]!=0). x0 counter is always 0.
  - waw_full = writes_rd && cnt[rd]==max.
- Outputs:
  - stall = DE_V && (BR_WAIT_Q || src_haz || waw_full).
  - ISSUE = DE_V && !stall.
  - V_DE_FE_BR_STALL = BR_WAIT_Q || (DE_V && is_ctrl).
- Counter update per cycle:
  - inc = ISSUE && writes_rd (on rd).
  - dec = WB_V && WB_REG_WEN && WB_DR!=0 && cnt[WB_DR]!=0 (on WB_DR).
  - Same register inc and dec in the same cycle: count unchanged.
  - Different registers: both apply.
  - Counter never wraps. Saturation is prevented by waw_full.
- Underflow: WB_V && WB_REG_WEN && WB_DR!=0 && cnt[WB_DR]==0 → counter unchanged, SB_ERR set (sticky until RESET).
- Writeback in the same cycle as a source read of that register: still stalls this cycle. Hazard uses registered counts, with no same-cycle bypass. Issue happens next cycle.
- FSM states: IDLE, BR_WAIT.
  - IDLE → BR_WAIT when ISSUE && is_ctrl.
  - BR_WAIT → IDLE when BR_RESOLVE.
  - BR_RESOLVE in IDLE is ignored.
  - ISSUE && is_ctrl and BR_RESOLVE together in IDLE → BR_WAIT (resolve belongs to no one).
  - In BR_WAIT, decode is stalled regardless of hazards. A new control instruction cannot issue until IDLE.
- Reset (synchronous, priority over all): all counters 0, SB_PENDING=0, FSM IDLE, BR_WAIT_Q=0, SB_ERR=0.
  - RESET asserted mid-branch or with pending writes discards all state.
  - Combinational outputs then follow DE_V with zero state.
- Latency: counter/FSM updates are visible the cycle after ISSUE/writeback.

Optional Feature:
- Macro SB_PERF_CNT_EN. When defined, adds two outputs:
  - PERF_HAZ_STALLS[31:0]: increments each cycle DE_V && !BR_WAIT_Q && (src_haz||waw_full).
  - PERF_BR_STALLS[31:0]: increments each cycle BR_WAIT_Q.
  - Both are zeroed by RESET and wrap at 2^32.
- When undefined, the ports and registers are absent and functional behaviour is identical.

Decomposition:
- Shared package: opcode constants (OPC_LOAD=5'b00000, OPC_OP_IMM, OPC_OP_IMM32, OPC_STORE, OPC_OP, OPC_OP32, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR), FSM state encoding (BR_IDLE=0, BR_WAIT=1).
- One natural sub-module: sb_counter_bank (NREG×CNT_W counters with inc/dec index ports, pending vector and saturation/underflow flags). Decode and FSM stay in the top module.

Test Plan:
- Reset, then DE_IR=ADDI x5,x0,1 with DE_V=1 → ISSUE=1, stall=0; next cycle SB_PENDING[5]=1. WB_V=1, WB_REG_WEN=1, WB_DR=5 → next cycle SB_PENDING=0.
- ADD x6,x5,x5 with SB_PENDING[5]=1 → stall=1, ISSUE=0 until cycle after writeback of x5, then ISSUE=1.
- Issue ADDI x7 three times (CNT_W=2) → cnt[7]=3. Fourth ADDI x7 → stall=1 (waw_full). One WB x7 → fourth issues next cycle.
- BEQ x1,x2 issued (x1,x2 clear) → V_DE_FE_BR_STALL=1 same cycle, BR_WAIT_Q=1 next. ADDI in decode stalled until BR_RESOLVE pulse → BR_WAIT_Q=0 next cycle, ADDI issues.
- ISSUE of ADDI x9 coincident with WB x9 at cnt[9]=1 → cnt[9] stays 1. WB to x3 with cnt[3]=0 → SB_ERR=1, stays set.
- RESET asserted in BR_WAIT with cnt[5]=2 → next cycle BR_WAIT_Q=0, SB_PENDING=0, SB_ERR=0; ADD x6,x5,x5 issues immediately.
